updn_mod_counter: RTL and testbench

UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

---
 rtl/updn_mod_counter.sv | 69 ++++++
 tb/tb_updn_mod_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/updn_mod_counter.sv
// Up/down modulo-N counter with selectable wrap or saturate behaviour at the
// range ends, parallel load with range checking, and registered status pulses.
module updn_mod_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter bit     SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] r_reg,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // MODULUS may equal 2**WIDTH (up to 2**32), so range checks run at 64 bits.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [63:0]      MOD64   = 64'(MODULUS);

  logic [63:0] load_val_ext;
  logic        at_top;
  logic        at_bot;
  logic        load_oor;

  assign load_val_ext = 64'(load_val);
  assign load_oor     = (load_val_ext >= MOD64);
  assign at_top       = (r_reg == MAX_VAL);
  assign at_bot       = (r_reg == '0);
  assign tc           = en & (up_dn ? at_top : at_bot);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reg    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        r_reg <= '0;
      end else if (load) begin
        r_reg    <= load_oor ? MAX_VAL : load_val;
        load_err <= load_oor;
      end else if (en) begin
        if (up_dn) begin
          if (at_top) begin
            r_reg <= SAT_MODE ? MAX_VAL : '0;
            wrap  <= 1'b1;
          end else begin
            r_reg <= r_reg + 1'b1;
          end
        end else begin
          if (at_bot) begin
            r_reg <= SAT_MODE ? '0 : MAX_VAL;
            wrap  <= 1'b1;
          end else begin
            r_reg <= r_reg - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_updn_mod_counter.sv
// Directed bench for updn_mod_counter: three instances (mod-10 wrap, mod-10
// saturate, mod-16 wrap) share one stimulus stream.
module tb_updn_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up_dn;

  logic [3:0] a_r, b_r, c_r;
  logic       a_tc, b_tc, c_tc;
  logic       a_wrap, b_wrap, c_wrap;
  logic       a_err, b_err, c_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  updn_mod_counter #(.WIDTH(4), .MODULUS(10), .SAT_MODE(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .r_reg(a_r), .tc(a_tc), .wrap(a_wrap), .load_err(a_err));

  updn_mod_counter #(.WIDTH(4), .MODULUS(10), .SAT_MODE(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .r_reg(b_r), .tc(b_tc), .wrap(b_wrap), .load_err(b_err));

  updn_mod_counter #(.WIDTH(4), .MODULUS(16), .SAT_MODE(1'b0)) dut_c (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .r_reg(c_r), .tc(c_tc), .wrap(c_wrap), .load_err(c_err));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    en       = 1'b0;
    up_dn    = 1'b1;

    // Held in reset while en toggles
    for (int i = 0; i < 4; i++) begin
      en = i[0];
      tick();
      chk("rst_r", int'(a_r), 0);
      chk("rst_wrap", int'(a_wrap), 0);
      chk("rst_err", int'(a_err), 0);
    end
    $display("txn reset held: r=%0d wrap=%0d err=%0d", a_r, a_wrap, a_err);

    reset_n = 1'b1;
    en      = 1'b1;
    up_dn   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("post_rst_count", int'(a_r), k);
      $display("txn count up: r=%0d", a_r);
    end

    // Load with en=1 takes the loaded value, no increment
    load = 1'b1; load_val = 4'd8;
    tick();
    chk("load_no_inc", int'(a_r), 8);
    $display("txn load 8 en=1: r=%0d", a_r);
    load = 1'b0;

    tick();
    chk("up_to_9", int'(a_r), 9);
    chk("tc_at_9", int'(a_tc), 1);
    chk("wrap_before", int'(a_wrap), 0);
    $display("txn up: r=%0d tc=%0d", a_r, a_tc);

    tick();
    chk("wrap_to_0", int'(a_r), 0);
    chk("wrap_pulse", int'(a_wrap), 1);
    chk("tc_after_wrap", int'(a_tc), 0);
    chk("sat_hold_9", int'(b_r), 9);
    chk("sat_wrap_up", int'(b_wrap), 1);
    chk("m16_no_wrap", int'(c_r), 10);
    chk("m16_wrap0", int'(c_wrap), 0);
    $display("txn wrap: a=%0d/%0d b=%0d/%0d c=%0d", a_r, a_wrap, b_r, b_wrap, c_r);

    tick();
    chk("after_wrap_1", int'(a_r), 1);
    chk("wrap_one_cycle", int'(a_wrap), 0);
    chk("sat_wrap_again", int'(b_wrap), 1);
    $display("txn up: a=%0d b=%0d", a_r, b_r);

    // Down count across zero
    load = 1'b1; load_val = 4'd1;
    tick();
    chk("load_1", int'(a_r), 1);
    load = 1'b0; up_dn = 1'b0;
    tick();
    chk("down_to_0", int'(a_r), 0);
    chk("tc_down_0", int'(a_tc), 1);
    chk("sat_down_0", int'(b_r), 0);
    tick();
    chk("down_wrap_9", int'(a_r), 9);
    chk("down_wrap_pulse", int'(a_wrap), 1);
    chk("sat_hold_0", int'(b_r), 0);
    chk("sat_wrap_dn1", int'(b_wrap), 1);
    tick();
    chk("down_8", int'(a_r), 8);
    chk("down_wrap_clr", int'(a_wrap), 0);
    chk("sat_hold_0b", int'(b_r), 0);
    chk("sat_wrap_dn2", int'(b_wrap), 1);
    $display("txn down: a=%0d b=%0d/%0d", a_r, b_r, b_wrap);

    // en=0 holds and ignores up_dn
    en = 1'b0; up_dn = 1'b1;
    tick();
    chk("hold_r", int'(a_r), 8);
    chk("hold_wrap", int'(a_wrap), 0);
    chk("hold_tc", int'(a_tc), 0);
    $display("txn hold: r=%0d", a_r);

    // Out-of-range load
    load = 1'b1; load_val = 4'd12;
    tick();
    chk("oor_load_r", int'(a_r), 9);
    chk("oor_load_err", int'(a_err), 1);
    chk("m16_load12", int'(c_r), 12);
    chk("m16_load12_err", int'(c_err), 0);
    load = 1'b0;
    tick();
    chk("err_one_cycle", int'(a_err), 0);
    chk("err_hold_r", int'(a_r), 9);
    $display("txn load 12: a=%0d c=%0d", a_r, c_r);

    load = 1'b1; load_val = 4'd5;
    tick();
    chk("load5_r", int'(a_r), 5);
    chk("load5_err", int'(a_err), 0);
    $display("txn load 5: r=%0d err=%0d", a_r, a_err);

    // Clear beats load and en
    clear = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1;
    tick();
    chk("clear_prio_a", int'(a_r), 0);
    chk("clear_prio_c", int'(c_r), 0);
    $display("txn clear+load+en: a=%0d c=%0d", a_r, c_r);
    clear = 1'b0;

    // Full-range modulus wraps from 15 without overflow
    load = 1'b1; load_val = 4'd15; en = 1'b0;
    tick();
    chk("m16_load15", int'(c_r), 15);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #1;
    chk("m16_tc15", int'(c_tc), 1);
    tick();
    chk("m16_wrap_r", int'(c_r), 0);
    chk("m16_wrap_p", int'(c_wrap), 1);
    tick();
    chk("m16_count1", int'(c_r), 1);
    $display("txn m16 wrap: c=%0d", c_r);

    // Asynchronous reset mid-cycle
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_c", int'(c_r), 0);
    chk("async_rst_a", int'(a_r), 0);
    chk("async_rst_err", int'(a_err), 0);
    #1 reset_n = 1'b1;
    tick();
    chk("resume_c", int'(c_r), 1);
    $display("txn async reset: c=%0d", c_r);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
